code_entry_unit: RTL

Datapath responder to the lock controller FSM. It captures keypad digits while the controller asserts read_input and holds the programming code (PC) and user code (UC) plus a first-entry temp buffer. For the controller's compareType it returns correct_input, data_ready, validLength and validLengthPC. On the controller's store request it commits a new user code.

---
 rtl/lock_pkg.sv | 21 ++
 rtl/key_edge_detect.sv | 23 ++
 rtl/code_entry_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared definitions between the lock controller FSM and the code entry datapath.
package lock_pkg;

  typedef enum logic [1:0] {
    COMPAREPC = 2'b00,
    COMPAREUC = 2'b01,
    MATCHUC   = 2'b10,
    STOREUC   = 2'b11
  } compare_type_e;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_ENTER  = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;
  localparam logic [3:0] DIGIT_MAX  = 4'd6;

  // Keys above DIGIT_MAX are either controller keys or unused, never code digits.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Keypad strobe edge detector: a press is the 1->0 transition of bstate.
module key_edge_detect (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       i_bstate,
  input  logic [3:0] i_button,
  output logic       o_press,
  output logic [3:0] o_key
);

  logic r_prev_bstate;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) r_prev_bstate <= 1'b0;
    else        r_prev_bstate <= i_bstate;
  end

  // The key value is taken in the same cycle the press pulse is high.
  assign o_press = r_prev_bstate & ~i_bstate;
  assign o_key   = i_button;

endmodule

// File: rtl/code_entry_unit.sv
// Keypad code entry datapath: captures digits, holds PC/UC/temp codes and reports compares.
module code_entry_unit
  import lock_pkg::*;
#(
  parameter int                   MAX_LEN      = 8,
  parameter int                   MIN_LEN      = 4,
  parameter int                   PC_LEN       = 4,
  parameter logic [4*MAX_LEN-1:0] PC_CODE      = 'h0000_1234,
  parameter logic [4*MAX_LEN-1:0] UC_RESET     = 'h0000_3210,
  parameter int                   UC_RESET_LEN = 4
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic [3:0] button,
  input  logic       bstate,
  input  logic       read_input,
  input  logic [1:0] compareType,
  input  logic       store,
  output logic       correct_input,
  output logic       data_ready,
  output logic       validLength,
  output logic       validLengthPC
);

  localparam int BW = 4 * MAX_LEN;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_LEN_V = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_LEN_V = LW'(MIN_LEN);
  localparam logic [LW-1:0] PC_LEN_V  = LW'(PC_LEN);

  logic          w_press;
  logic [3:0]    w_key;
  compare_type_e w_ct;
  logic          w_session_start;
  logic          w_digit_press;
  logic          w_store_edge;
  logic          w_match;

  logic          r_prev_read_input;
  logic          r_prev_store;
  compare_type_e r_prev_ct;
  logic [BW-1:0] r_entry;
  logic [LW-1:0] r_entry_len;
  logic          r_overflow;
  logic [BW-1:0] r_temp;
  logic [LW-1:0] r_temp_len;
  logic [BW-1:0] r_uc;
  logic [LW-1:0] r_uc_len;
  logic          r_correct;
  logic          r_data_ready;
  logic          r_valid_len;
  logic          r_valid_len_pc;

  key_edge_detect u_key_edge_detect (
    .hwclk    (hwclk),
    .rst_n    (rst_n),
    .i_bstate (bstate),
    .i_button (button),
    .o_press  (w_press),
    .o_key    (w_key)
  );

  assign w_ct            = compare_type_e'(compareType);
  assign w_session_start = read_input & (~r_prev_read_input | (w_ct != r_prev_ct));
  assign w_digit_press   = w_press & is_digit(w_key) & read_input & ~w_session_start;
  assign w_store_edge    = store & ~r_prev_store & (r_temp_len != '0);

  // Digits past the shorter length never take part; lengths must match first.
  function automatic logic codes_equal(input logic [BW-1:0] a, input logic [LW-1:0] a_len,
                                       input logic [BW-1:0] b, input logic [LW-1:0] b_len);
    logic eq;
    eq = (a_len == b_len);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(a_len)) && (a[i*4 +: 4] != b[i*4 +: 4])) eq = 1'b0;
    end
    return eq;
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_match = 1'b0;
    case (w_ct)
      COMPAREPC: w_match = codes_equal(r_entry, r_entry_len, PC_CODE, PC_LEN_V);
      COMPAREUC: w_match = codes_equal(r_entry, r_entry_len, r_uc, r_uc_len);
      MATCHUC:   w_match = codes_equal(r_entry, r_entry_len, r_temp, r_temp_len);
      default:   w_match = 1'b0;
    endcase
    if (r_overflow) w_match = 1'b0;
  end

  // NOTE: the code buffers are small flop arrays, so they are reset like any other register.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_read_input <= 1'b0;
      r_prev_store      <= 1'b0;
      r_prev_ct         <= COMPAREPC;
      r_entry           <= '0;
      r_entry_len       <= '0;
      r_overflow        <= 1'b0;
      r_temp            <= '0;
      r_temp_len        <= '0;
      r_uc              <= UC_RESET;
      r_uc_len          <= LW'(UC_RESET_LEN);
    end else begin
      r_prev_read_input <= read_input;
      r_prev_store      <= store;
      r_prev_ct         <= w_ct;

      if (w_session_start) begin
        // A finished STOREUC entry becomes the first-entry copy for the confirm step.
        if (r_prev_ct == STOREUC) begin
          r_temp     <= r_entry;
          r_temp_len <= r_entry_len;
        end
        r_entry_len <= '0;
        r_overflow  <= 1'b0;
      end else if (w_digit_press) begin
        if (r_entry_len == MAX_LEN_V) begin
          r_overflow <= 1'b1;
        end else begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (i == int'(r_entry_len)) r_entry[i*4 +: 4] <= w_key;
          end
          r_entry_len <= r_entry_len + LW'(1);
        end
      end

      if (w_store_edge) begin
        r_uc     <= r_temp;
        r_uc_len <= r_temp_len;
      end
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_correct      <= 1'b0;
      r_data_ready   <= 1'b0;
      r_valid_len    <= 1'b0;
      r_valid_len_pc <= 1'b0;
    end else begin
      r_correct      <= w_match;
      // High only once read_input has been low for two sampled cycles.
      r_data_ready   <= ~read_input & ~r_prev_read_input;
      r_valid_len    <= ~r_overflow & (r_entry_len >= MIN_LEN_V) & (r_entry_len <= MAX_LEN_V);
      r_valid_len_pc <= ~r_overflow & (r_entry_len == PC_LEN_V);
    end
  end

  assign correct_input = r_correct;
  assign data_ready    = r_data_ready;
  assign validLength   = r_valid_len;
  assign validLengthPC = r_valid_len_pc;

endmodule
